trigger_capture: RTL and testbench

Acquisition front end for the oscilloscope sample path. It watches the ADC sample stream for a programmable level/edge trigger, then streams a fixed number of post-trigger samples into the write side of the dual-clock sample FIFO. It drives the FIFO write-pointer increment and write data, and honours the FIFO full flag. It lives entirely in the ADC clock domain.

---
 rtl/trigger_capture.sv | 196 +++++++++++++++++++
 tb/tb_trigger_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// Level/edge trigger and fixed-length post-trigger capture into the FIFO write side.
// Optional auto-trigger on timeout is enabled by defining TRIG_AUTO_EN.
module trigger_capture #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned AUTO_TIMEOUT = 200
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic                  edge_sel_i,
  input  logic [CNT_WIDTH-1:0]  post_len_i,
  input  logic                  fifo_full_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_inc_o,
  output logic                  armed_o,
  output logic                  triggered_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  auto_o
);

  localparam int unsigned LEN_W = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  if (AUTO_TIMEOUT < 1) begin : g_cfg_err
    $error("AUTO_TIMEOUT must be at least 1");
  end

  state_t                r_state,     w_state_nxt;
  logic [DATA_WIDTH-1:0] r_level,     w_level_nxt;
  logic                  r_edge_sel,  w_edge_sel_nxt;
  logic [LEN_W-1:0]      r_len,       w_len_nxt;
  logic [LEN_W-1:0]      r_cnt,       w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_prev,      w_prev_nxt;
  logic                  r_prev_vld,  w_prev_vld_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data,   w_wr_data_nxt;
  logic                  r_wr_inc,    w_wr_inc_nxt;
  logic                  r_trig,      w_trig_nxt;
  logic                  r_ovf,       w_ovf_nxt;
  logic                  w_edge;
  logic                  w_fire;
  logic                  w_cap;
  logic [LEN_W-1:0]      w_cnt_inc;

`ifdef TRIG_AUTO_EN
  localparam int unsigned AUTO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [AUTO_W-1:0]     r_auto_cnt,  w_auto_cnt_nxt;
  logic                  r_auto,      w_auto_nxt;
  logic                  w_auto_fire;
  assign w_auto_fire = (r_auto_cnt == AUTO_W'(AUTO_TIMEOUT));
`endif

  // Edge qualification against the previous valid sample (unsigned compare)
  always_comb begin
    w_edge = 1'b0;
    if (r_prev_vld) begin
      if (r_edge_sel) w_edge = (r_prev > r_level) && (sample_i <= r_level);
      else            w_edge = (r_prev < r_level) && (sample_i >= r_level);
    end
  end

  assign w_cnt_inc = LEN_W'(r_cnt + LEN_W'(1));

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_edge_sel_nxt = r_edge_sel;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_prev_nxt     = r_prev;
    w_prev_vld_nxt = r_prev_vld;
    w_wr_data_nxt  = r_wr_data;
    w_wr_inc_nxt   = 1'b0;
    w_trig_nxt     = 1'b0;
    w_ovf_nxt      = r_ovf;
    w_fire         = 1'b0;
    w_cap          = 1'b0;
`ifdef TRIG_AUTO_EN
    w_auto_cnt_nxt = r_auto_cnt;
    w_auto_nxt     = r_auto;
`endif

    if (abort_i) begin
      w_state_nxt = ST_IDLE;
    end else if (arm_i && (r_state == ST_IDLE || r_state == ST_DONE)) begin
      w_state_nxt    = ST_ARMED;
      w_level_nxt    = level_i;
      w_edge_sel_nxt = edge_sel_i;
      w_len_nxt      = (post_len_i == '0) ? LEN_W'(1) : LEN_W'(post_len_i);
      w_cnt_nxt      = '0;
      w_prev_vld_nxt = 1'b0;
      w_ovf_nxt      = 1'b0;
`ifdef TRIG_AUTO_EN
      w_auto_cnt_nxt = '0;
      w_auto_nxt     = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (sample_valid_i) begin
            w_prev_nxt     = sample_i;
            w_prev_vld_nxt = 1'b1;
            w_fire         = w_edge;
`ifdef TRIG_AUTO_EN
            if (!w_auto_fire) w_auto_cnt_nxt = AUTO_W'(r_auto_cnt + AUTO_W'(1));
            if (w_auto_fire && !w_edge) begin
              w_fire     = 1'b1;
              w_auto_nxt = 1'b1;
            end
`endif
            if (w_fire) begin
              w_state_nxt = ST_CAPTURE;
              w_trig_nxt  = 1'b1;
              w_cap       = 1'b1;
            end
          end
        end
        ST_CAPTURE: w_cap = sample_valid_i;
        default: ;
      endcase

      // Counter advances even on a dropped sample to keep time alignment
      if (w_cap) begin
        w_cnt_nxt = w_cnt_inc;
        if (fifo_full_i) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_wr_data_nxt = sample_i;
          w_wr_inc_nxt  = 1'b1;
        end
        if (w_cnt_inc >= r_len) w_state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_level    <= '0;
      r_edge_sel <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_wr_data  <= '0;
      r_wr_inc   <= 1'b0;
      r_trig     <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef TRIG_AUTO_EN
      r_auto_cnt <= '0;
      r_auto     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_edge_sel <= w_edge_sel_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prev     <= w_prev_nxt;
      r_prev_vld <= w_prev_vld_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_wr_inc   <= w_wr_inc_nxt;
      r_trig     <= w_trig_nxt;
      r_ovf      <= w_ovf_nxt;
`ifdef TRIG_AUTO_EN
      r_auto_cnt <= w_auto_cnt_nxt;
      r_auto     <= w_auto_nxt;
`endif
    end
  end

  assign wr_data_o   = r_wr_data;
  assign wr_inc_o    = r_wr_inc;
  assign triggered_o = r_trig;
  assign overflow_o  = r_ovf;
  assign armed_o     = (r_state == ST_ARMED);
  assign done_o      = (r_state == ST_DONE);
`ifdef TRIG_AUTO_EN
  assign auto_o      = r_auto;
`else
  assign auto_o      = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: expected FIFO writes are queued by the
// stimulus thread and checked by an independent monitor on every strobe.
module tb_trigger_capture;

`ifdef TRIG_AUTO_EN
  localparam int unsigned TB_AUTO = 5;
`else
  localparam int unsigned TB_AUTO = 200;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       arm_i;
  logic       abort_i;
  logic [7:0] level_i;
  logic       edge_sel_i;
  logic [7:0] post_len_i;
  logic       fifo_full_i;
  logic [7:0] wr_data_o;
  logic       wr_inc_o;
  logic       armed_o;
  logic       triggered_o;
  logic       done_o;
  logic       overflow_o;
  logic       auto_o;

  trigger_capture #(
    .DATA_WIDTH  (8),
    .CNT_WIDTH   (8),
    .AUTO_TIMEOUT(TB_AUTO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .level_i       (level_i),
    .edge_sel_i    (edge_sel_i),
    .post_len_i    (post_len_i),
    .fifo_full_i   (fifo_full_i),
    .wr_data_o     (wr_data_o),
    .wr_inc_o      (wr_inc_o),
    .armed_o       (armed_o),
    .triggered_o   (triggered_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o),
    .auto_o        (auto_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       trig;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic t, input logic l);
    exp_t e;
    e.data = d;
    e.trig = t;
    e.last = l;
    q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (wr_inc_o) begin
          if (q.size() == 0) begin
            check("unexpected_strobe", 32'(wr_data_o), 32'h100);
          end else begin
            e = q.pop_front();
            check("wr_data", 32'(wr_data_o), 32'(e.data));
            check("trig_with_wr", 32'(triggered_o), 32'(e.trig));
            check("done_with_wr", 32'(done_o), 32'(e.last));
          end
        end else if (triggered_o) begin
          check("trig_without_wr", 32'(triggered_o), 32'h0);
        end
      end
    end
  end

  task automatic drv(input logic [7:0] s, input logic v, input logic f);
    sample_i       = s;
    sample_valid_i = v;
    fifo_full_i    = f;
    @(negedge clk_i);
  endtask

  // Arm, then scramble the configuration inputs to prove they were latched
  task automatic arm_cfg(input logic [7:0] lvl, input logic es, input logic [7:0] len);
    level_i        = lvl;
    edge_sel_i     = es;
    post_len_i     = len;
    arm_i          = 1'b1;
    sample_valid_i = 1'b0;
    fifo_full_i    = 1'b0;
    @(negedge clk_i);
    arm_i      = 1'b0;
    level_i    = 8'h00;
    edge_sel_i = ~es;
    post_len_i = 8'd1;
  endtask

  task automatic q_empty(input string name);
    check(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; sample_i = '0; sample_valid_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0;
    level_i = '0; edge_sel_i = 1'b0; post_len_i = '0; fifo_full_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_wr_inc", 32'(wr_inc_o), 0);
    check("rst_wr_data", 32'(wr_data_o), 0);
    check("rst_armed", 32'(armed_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_flags", 32'({triggered_o, overflow_o, auto_o}), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Rising trigger on a ramp
    arm_cfg(8'h80, 1'b0, 8'd4);
    check("armed_after_arm", 32'(armed_o), 1);
    drv(8'h70, 1, 0);
    drv(8'h78, 1, 0);
    expect_wr(8'h80, 1, 0); drv(8'h80, 1, 0);
    expect_wr(8'h88, 0, 0); drv(8'h88, 1, 0);
    expect_wr(8'h90, 0, 0); drv(8'h90, 1, 0);
    expect_wr(8'h98, 0, 1); drv(8'h98, 1, 0);
    drv(8'hA0, 1, 0);
    drv(8'hA8, 1, 0);
    check("rise_done", 32'(done_o), 1);
    check("rise_armed_low", 32'(armed_o), 0);
    check("rise_data_hold", 32'(wr_data_o), 32'h98);
    q_empty("rise_q_empty");

    // Falling edge; a level sample with no valid prev must not trigger
    arm_cfg(8'h40, 1'b1, 8'd2);
    drv(8'h40, 1, 0);
    drv(8'h50, 1, 0);
    expect_wr(8'h40, 1, 0); drv(8'h40, 1, 0);
    expect_wr(8'h30, 0, 1); drv(8'h30, 1, 0);
    check("fall_done", 32'(done_o), 1);
    q_empty("fall_q_empty");

    // Full FIFO on 3rd/4th capture samples; arm mid-capture is ignored
    arm_cfg(8'h80, 1'b0, 8'd6);
    drv(8'h70, 1, 0);
    expect_wr(8'h80, 1, 0); drv(8'h80, 1, 0);
    expect_wr(8'h81, 0, 0); drv(8'h81, 1, 0);
    drv(8'h82, 1, 1);
    check("ovf_set", 32'(overflow_o), 1);
    drv(8'h83, 1, 1);
    arm_i = 1'b1;
    expect_wr(8'h84, 0, 0); drv(8'h84, 1, 0);
    arm_i = 1'b0;
    check("done_not_early", 32'(done_o), 0);
    expect_wr(8'h85, 0, 1); drv(8'h85, 1, 0);
    check("full_done", 32'(done_o), 1);
    check("full_ovf_sticky", 32'(overflow_o), 1);
    q_empty("full_q_empty");

    // Gapped valid stream, every 3rd cycle
    arm_cfg(8'h80, 1'b0, 8'd3);
    check("ovf_cleared_on_arm", 32'(overflow_o), 0);
    drv(8'h10, 1, 0); drv(8'hEE, 0, 0); drv(8'hEE, 0, 0);
    expect_wr(8'h90, 1, 0);
    drv(8'h90, 1, 0); drv(8'hEE, 0, 0); drv(8'hEE, 0, 0);
    expect_wr(8'h91, 0, 0);
    drv(8'h91, 1, 0); drv(8'hEE, 0, 0); drv(8'hEE, 0, 0);
    expect_wr(8'h92, 0, 1);
    drv(8'h92, 1, 0); drv(8'hEE, 0, 0);
    check("gap_done", 32'(done_o), 1);
    q_empty("gap_q_empty");

    // Abort after the 2nd capture sample; the same-cycle sample is not written
    arm_cfg(8'h80, 1'b0, 8'd6);
    drv(8'h70, 1, 0);
    expect_wr(8'h80, 1, 0); drv(8'h80, 1, 0);
    expect_wr(8'h81, 0, 0); drv(8'h81, 1, 0);
    abort_i = 1'b1;
    drv(8'h82, 1, 0);
    abort_i = 1'b0;
    check("abort_wr_inc", 32'(wr_inc_o), 0);
    check("abort_armed", 32'(armed_o), 0);
    check("abort_done", 32'(done_o), 0);
    drv(8'h70, 1, 0); drv(8'h90, 1, 0); drv(8'h91, 1, 0);
    check("abort_idle_done", 32'(done_o), 0);
    q_empty("abort_q_empty");

    // Reset mid-capture clears outputs asynchronously
    arm_cfg(8'h80, 1'b0, 8'd6);
    drv(8'h70, 1, 0);
    expect_wr(8'h80, 1, 0); drv(8'h80, 1, 0);
    expect_wr(8'h81, 0, 0); drv(8'h81, 1, 0);
    sample_i = 8'h82;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("arst_wr_inc", 32'(wr_inc_o), 0);
    check("arst_wr_data", 32'(wr_data_o), 0);
    check("arst_armed", 32'(armed_o), 0);
    check("arst_done", 32'(done_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drv(8'h90, 1, 0);
    q_empty("arst_q_empty");

    // Simultaneous arm and abort ends in IDLE
    arm_i = 1'b1; abort_i = 1'b1;
    drv(8'h00, 0, 0);
    arm_i = 1'b0; abort_i = 1'b0;
    check("arm_abort_idle", 32'(armed_o), 0);

    // post_len of 0 behaves as 1
    arm_cfg(8'h80, 1'b0, 8'd0);
    drv(8'h70, 1, 0);
    expect_wr(8'h80, 1, 1); drv(8'h80, 1, 0);
    drv(8'h81, 1, 0);
    check("len0_done", 32'(done_o), 1);
    q_empty("len0_q_empty");

    // Flat input below level
    arm_cfg(8'h80, 1'b0, 8'd1);
`ifdef TRIG_AUTO_EN
    repeat (5) drv(8'h10, 1, 0);
    check("auto_not_early", 32'(armed_o), 1);
    expect_wr(8'h10, 1, 1); drv(8'h10, 1, 0);
    check("auto_flag", 32'(auto_o), 1);
    check("auto_done", 32'(done_o), 1);
    arm_cfg(8'h80, 1'b0, 8'd1);
    check("auto_cleared_on_arm", 32'(auto_o), 0);
`else
    repeat (1000) drv(8'h10, 1, 0);
    check("noauto_still_armed", 32'(armed_o), 1);
    check("noauto_flag", 32'(auto_o), 0);
`endif
    abort_i = 1'b1;
    drv(8'h10, 0, 0);
    abort_i = 1'b0;
    drv(8'h10, 0, 0);
    q_empty("final_q_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
